alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Writeback/commit stage directly downstream of the ALU.
- Captures the ALU's result words, status byte and updated stack pointer. Sequences register-file writes, including the two-word MULT result over two cycles.
- Owns the architectural status register and stack pointer, and back-pressures the ALU/issue stage while a MULT high-word write is pending.
- Tracks stack-bounds faults and counts retired instructions.

Parameters:
- STACK_BASE, 12'h000, lowest legal stack pointer value.
- STACK_LIMIT, 12'h0FF, highest legal stack pointer value.
- SR_RESET, 8'h00, reset value of the status register.

Ports:
- CLOCK  in  1  single system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result present this cycle.
- in_ready  out  1  stage can accept; the transfer occurs when in_valid and in_ready are both high.
- in_rd  in  3  destination register address.
- in_rd_we  in  1  instruction writes a register.
- in_is_mult  in  1  result is 32-bit; write lo to rd, hi to rd+1.
- in_lo  in  16  ALU aluout1.
- in_hi  in  16  ALU aluout2 (used only when in_is_mult).
- in_status  in  8  ALU statusregout.
- in_sp_we  in  1  instruction updates the stack pointer.
- in_sp  in  12  ALU decremented_stack_reg (new SP value).
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  3  register-file write address.
- rf_wdata  out  16  register-file write data.
- status_reg  out  8  architectural status register, fed back to ALU statusregin.
- stack_reg  out  12  architectural stack pointer, fed back to ALU stack_reg.
- stack_fault  out  1  sticky: an out-of-bounds SP write was attempted.
- retire_count  out  16  number of accepted instructions.

Behaviour:
- Reset values (asynchronous, immediate on RESET high):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - status_reg=SR_RESET, stack_reg=STACK_BASE.
  - stack_fault=0, retire_count=0.
  - FSM in IDLE.
- FSM states: IDLE, MULT_HI.
- IDLE:
  - in_ready=1.
  - On accept (cycle T), registered at the T edge:
    - status_reg<=in_status.
    - retire_count<=retire_count+1, wrapping 16'hFFFF->0.
    - If in_rd_we: rf_we<=1, rf_waddr<=in_rd, rf_wdata<=in_lo; visible in cycle T+1 (latency 1). Otherwise rf_we<=0.
    - If in_rd_we and in_is_mult: latch hi_buf<=in_hi and hi_addr<=in_rd+1 (3-bit wrap, 7->0); go to MULT_HI.
  - No accept: rf_we<=0.
- MULT_HI:
  - in_ready=0 (combinational from state); in_valid is ignored.
  - Next edge: rf_we<=1, rf_waddr<=hi_addr, rf_wdata<=hi_buf, so the high word is visible in T+2.
  - Return to IDLE; in_ready=1 again in T+2.
  - The hi write does not change status_reg, stack_reg or retire_count.
- in_is_mult with in_rd_we=0: no writes, no MULT_HI.
- Stack pointer on accept with in_sp_we:
  - If STACK_BASE <= in_sp <= STACK_LIMIT (unsigned): stack_reg<=in_sp.
  - Otherwise: stack_reg holds and stack_fault<=1. The register write and status update of the same instruction still occur.
  - Upstream ±1 wrap (e.g. 12'h000 -> 12'hFFF) is caught by this check.
  - stack_fault clears only on RESET.
- No combinational path from in_* to rf_* outputs; in_ready depends only on state.
- RESET asserted mid-MULT_HI: FSM to IDLE, pending hi write discarded, all outputs to reset values.

Test Plan:
- Reset: assert RESET asynchronously between edges -> immediately rf_we=0, status_reg=8'h00, stack_reg=12'h000, stack_fault=0, retire_count=0, in_ready=1.
- Single write: accept in_rd=3, in_rd_we=1, in_lo=16'hBEEF, in_status=8'h41 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=BEEF, status_reg=41, retire_count=1; cycle after, rf_we=0.
- MULT sequencing: accept in_rd=7, in_is_mult=1, lo=16'h5678, hi=16'h1234, with in_valid held high -> T+1 write r7=5678 with in_ready=0; T+2 write r0=1234 with in_ready=1; retire_count advances by exactly 1.
- Stack bounds: in_sp_we with in_sp=12'h010 -> stack_reg=010. Then in_sp=12'hFFF -> stack_reg stays 010, stack_fault=1. Then in_sp=12'h011 -> stack_reg=011 and stack_fault stays 1.
- Back-to-back single writes: in_valid held high for 4 cycles with rd=1..4 -> four consecutive rf_we pulses with matching addr/data; retire_count=4.
- Reset mid-MULT: assert RESET during MULT_HI -> no high-word write appears, FSM back to IDLE, retire_count=0.

Source files
------------

// File: rtl/alu_writeback.sv
// Writeback/commit stage behind the ALU: sequences register-file writes, including the two-beat MULT result,
// and owns the architectural status register, stack pointer, stack-fault flag and retire counter.
module alu_writeback #(
  parameter logic [11:0] STACK_BASE  = 12'h000,
  parameter logic [11:0] STACK_LIMIT = 12'h0FF,
  parameter logic [7:0]  SR_RESET    = 8'h00
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_rd,
  input  logic        in_rd_we,
  input  logic        in_is_mult,
  input  logic [15:0] in_lo,
  input  logic [15:0] in_hi,
  input  logic [7:0]  in_status,
  input  logic        in_sp_we,
  input  logic [11:0] in_sp,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [7:0]  status_reg,
  output logic [11:0] stack_reg,
  output logic        stack_fault,
  output logic [15:0] retire_count
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MULT_HI = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic        accept_s;
  logic        sp_ok_s;
  logic [12:0] sp_below_s;
  logic [15:0] hi_buf_r;
  logic [2:0]  hi_addr_r;
  logic        rf_we_r;
  logic [2:0]  rf_waddr_r;
  logic [15:0] rf_wdata_r;
  logic [7:0]  status_r;
  logic [11:0] stack_r;
  logic        fault_r;
  logic [15:0] retire_r;

  assign in_ready     = (state_r == IDLE);
  assign accept_s     = in_valid & in_ready;
  assign rf_we        = rf_we_r;
  assign rf_waddr     = rf_waddr_r;
  assign rf_wdata     = rf_wdata_r;
  assign status_reg   = status_r;
  assign stack_reg    = stack_r;
  assign stack_fault  = fault_r;
  assign retire_count = retire_r;

  // Unsigned bounds check; the lower bound uses a borrow so a zero base needs no always-true compare.
  always_comb begin
    sp_below_s = {1'b0, in_sp} - {1'b0, STACK_BASE};
    sp_ok_s    = ~sp_below_s[12] & (in_sp <= STACK_LIMIT);
  end

  // Next-state: only an accepted MULT that writes a register needs the extra high-word beat.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && in_rd_we && in_is_mult) begin
          state_nx_s = MULT_HI;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MULT_HI: state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Write port sequencing and high-word buffer.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 3'd0;
      rf_wdata_r <= 16'h0000;
      hi_buf_r   <= 16'h0000;
      hi_addr_r  <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && in_rd_we) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= in_rd;
            rf_wdata_r <= in_lo;
            if (in_is_mult) begin
              hi_buf_r  <= in_hi;
              hi_addr_r <= in_rd + 3'd1;
            end
          end else begin
            rf_we_r <= 1'b0;
          end
        end
        MULT_HI: begin
          rf_we_r    <= 1'b1;
          rf_waddr_r <= hi_addr_r;
          rf_wdata_r <= hi_buf_r;
        end
        default: rf_we_r <= 1'b0;
      endcase
    end
  end

  // Architectural state commits once per accepted instruction; the high-word beat leaves it alone.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      status_r <= SR_RESET;
      stack_r  <= STACK_BASE;
      fault_r  <= 1'b0;
      retire_r <= 16'h0000;
    end else if (accept_s) begin
      status_r <= in_status;
      retire_r <= retire_r + 16'd1;
      if (in_sp_we) begin
        if (sp_ok_s) begin
          stack_r <= in_sp;
        end else begin
          fault_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized scoreboard bench for alu_writeback against a transaction-level model of the commit rules.
module tb_alu_writeback;

  localparam int SP_LO = 0;
  localparam int SP_HI = 255;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_rd = 3'd0;
  logic        in_rd_we = 1'b0;
  logic        in_is_mult = 1'b0;
  logic [15:0] in_lo = 16'h0000;
  logic [15:0] in_hi = 16'h0000;
  logic [7:0]  in_status = 8'h00;
  logic        in_sp_we = 1'b0;
  logic [11:0] in_sp = 12'h000;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [7:0]  status_reg;
  logic [11:0] stack_reg;
  logic        stack_fault;
  logic [15:0] retire_count;

  alu_writeback dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_is_mult(in_is_mult), .in_lo(in_lo), .in_hi(in_hi), .in_status(in_status),
    .in_sp_we(in_sp_we), .in_sp(in_sp),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .status_reg(status_reg), .stack_reg(stack_reg), .stack_fault(stack_fault),
    .retire_count(retire_count)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t q[$];

  logic [7:0]  m_status = 8'h00;
  logic [11:0] m_sp = 12'h000;
  logic        m_fault = 1'b0;
  logic [15:0] m_retire = 16'h0000;
  logic        m_busy = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_status = 8'h00;
    m_sp     = 12'h000;
    m_fault  = 1'b0;
    m_retire = 16'h0000;
    m_busy   = 1'b0;
  endfunction

  // Monitor: matches every register-file write against the scoreboard and checks architectural state.
  always @(negedge CLOCK) begin
    if (!RESET) begin
      while (q.size() > 0 && q[0].c < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_write: got none expected r%0d=%h", q[0].a, q[0].d);
        void'(q.pop_front());
      end
      if (rf_we) begin
        if (q.size() == 0 || q[0].c != cyc) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got r%0d=%h expected no write (cycle %0d)", rf_waddr, rf_wdata, cyc);
        end else begin
          wr_t e;
          e = q.pop_front();
          check("rf_waddr", 32'(rf_waddr), 32'(e.a));
          check("rf_wdata", 32'(rf_wdata), 32'(e.d));
        end
      end
      check("status_reg", 32'(status_reg), 32'(m_status));
      check("stack_reg", 32'(stack_reg), 32'(m_sp));
      check("stack_fault", 32'(stack_fault), 32'(m_fault));
      check("retire_count", 32'(retire_count), 32'(m_retire));
    end
  end

  task automatic step(input logic v, input logic [2:0] rd, input logic we, input logic mult,
                      input logic [15:0] lo, input logic [15:0] hi, input logic [7:0] st,
                      input logic spwe, input logic [11:0] sp);
    logic acc;
    @(negedge CLOCK);
    check("in_ready", 32'(in_ready), 32'(!m_busy));
    in_valid = v; in_rd = rd; in_rd_we = we; in_is_mult = mult;
    in_lo = lo; in_hi = hi; in_status = st; in_sp_we = spwe; in_sp = sp;
    acc = v && !m_busy;
    @(posedge CLOCK);
    #1;
    if (acc) begin
      m_status = st;
      m_retire = m_retire + 16'd1;
      if (spwe) begin
        if (int'(sp) >= SP_LO && int'(sp) <= SP_HI) m_sp = sp;
        else m_fault = 1'b1;
      end
      if (we) q.push_back('{cyc, rd, lo});
      if (we && mult) q.push_back('{cyc + 1, rd + 3'd1, hi});
    end
    m_busy = acc && we && mult;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 8'h00, 1'b0, 12'h000);
  endtask

  // Asserts reset between clock edges and checks the values appear without waiting for an edge.
  task automatic do_reset();
    #2;
    RESET = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_status", 32'(status_reg), 32'h00);
    check("rst_stack", 32'(stack_reg), 32'h000);
    check("rst_fault", 32'(stack_fault), 32'd0);
    check("rst_retire", 32'(retire_count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge CLOCK);
    #2;
    RESET = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] sp;
    do_reset();
    // single write
    step(1'b1, 3'd3, 1'b1, 1'b0, 16'hBEEF, 16'h0, 8'h41, 1'b0, 12'h000);
    idle(2);
    // MULT with in_valid held high through the high-word beat
    step(1'b1, 3'd7, 1'b1, 1'b1, 16'h5678, 16'h1234, 8'h22, 1'b0, 12'h000);
    step(1'b1, 3'd2, 1'b1, 1'b0, 16'hAAAA, 16'h0, 8'h33, 1'b0, 12'h000);
    idle(2);
    // stack bounds
    step(1'b1, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 8'h01, 1'b1, 12'h010);
    step(1'b1, 3'd1, 1'b1, 1'b0, 16'h0101, 16'h0, 8'h02, 1'b1, 12'hFFF);
    step(1'b1, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 8'h03, 1'b1, 12'h011);
    step(1'b1, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 8'h04, 1'b1, 12'h0FF);
    step(1'b1, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 8'h05, 1'b1, 12'h100);
    // MULT with in_rd_we low: no writes, no stall
    step(1'b1, 3'd5, 1'b0, 1'b1, 16'h1111, 16'h2222, 8'h06, 1'b0, 12'h000);
    idle(1);
    // back-to-back single writes
    for (int i = 1; i <= 4; i++)
      step(1'b1, 3'(i), 1'b1, 1'b0, 16'(16'hC000 + i), 16'h0, 8'(i), 1'b0, 12'h000);
    idle(2);
    // reset during the high-word beat
    do_reset();
    step(1'b1, 3'd4, 1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 8'h77, 1'b0, 12'h000);
    do_reset();
    idle(3);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) sp = 12'($urandom_range(256, 4095));
      else sp = 12'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom), 8'($urandom),
           $urandom_range(0, 1) == 1, sp);
      if (n == 200) do_reset();
    end
    idle(3);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
